sam_pwm_rx: RTL and testbench

Parametrised serial-configured pulse-width demodulator for the SAM receive path. In configuration mode it shifts in a message length and a valid symbol-period window. In decode mode it classifies each high/low symbol on `str` as a 1 or a 0 by duty cycle and assembles a message of the configured length. It then replays the message MSB-first on `msg`, with `frame` marking the valid bits.

---
 rtl/sam_pwm_rx.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_sam_pwm_rx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sam_pwm_rx.sv
// sam_pwm_rx -- serial-configured pulse-width demodulator for the SAM receive path.
//
// While mode=1 a configuration word {LEN, MIN, MAX} is shifted in MSB first on
// str, one bit per clock. While mode=0 each high/low symbol on str is measured.
// A symbol whose period hi+lo lies in [MIN, MAX] decodes as 1 when hi >= lo and
// as 0 otherwise. A symbol outside the window is dropped and pulses err. After
// min(LEN, MSG_W) accepted bits the message is replayed MSB first (oldest bit
// first) on msg, with frame high for each valid bit.
//
// Optional feature macro: SAM_PARITY_EN. When defined, the symbol after the
// last data bit is an even-parity bit over the data bits. On a mismatch (or a
// rejected parity symbol) err pulses and the message is dropped.
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   reset        in   asynchronous active-low reset
//   str          in   config bit (mode=1) or PWM line (mode=0)
//   mode         in   1 = configuration load, 0 = decode
//   msg          out  replayed message bit, 0 whenever frame=0
//   frame        out  high while msg carries a valid message bit
//   cfg_done     out  high once a complete configuration word is loaded
//   err          out  one-cycle pulse on a rejected symbol / parity failure
//   dbg_state_o  out  current decode FSM state (IDLE=0 HIGH=1 LOW=2 OUT=3)
//
// Output handshake: frame is a valid with no ready. The consumer must take msg
// on every cycle frame is high; the block cannot be stalled.

module sam_pwm_rx #(
    parameter int MSG_W = 64,
    parameter int LEN_W = 7,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       str,
    input  logic       mode,
    output logic       msg,
    output logic       frame,
    output logic       cfg_done,
    output logic       err,
    output logic [1:0] dbg_state_o
);

    localparam int CFG_W  = LEN_W + 2 * CNT_W;
    localparam int CFG_CW = $clog2(CFG_W + 1);

    localparam logic [CFG_CW-1:0] CFG_ONE  = CFG_CW'(1);
    localparam logic [CFG_CW-1:0] CFG_LAST = CFG_CW'(CFG_W - 1);
    localparam logic [CFG_CW-1:0] CFG_FULL = CFG_CW'(CFG_W);
    localparam logic [LEN_W-1:0]  MSG_W_L  = LEN_W'(MSG_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                prev_str_q, prev_str_d;
    logic                mode_q, mode_d;
    logic [CFG_W-1:0]    cfg_sr_q, cfg_sr_d;
    logic [CFG_CW-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic                cfg_done_q, cfg_done_d;
    logic [CNT_W-1:0]    hi_q, hi_d;
    logic [CNT_W-1:0]    lo_q, lo_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]    out_cnt_q, out_cnt_d;
    logic [MSG_W-1:0]    msg_sr_q, msg_sr_d;
    logic                msg_q, msg_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;
`ifdef SAM_PARITY_EN
    logic                par_phase_q, par_phase_d;
    logic                par_acc_q, par_acc_d;
`endif

    // Configuration fields, in the order they were shifted in.
    logic [LEN_W-1:0]    cfg_len;
    logic [CNT_W-1:0]    cfg_min;
    logic [CNT_W-1:0]    cfg_max;
    logic [LEN_W-1:0]    eff_len;
    logic                decode_en;
    logic [CNT_W:0]      period;
    logic                in_window;
    logic                sym_bit;
    logic                last_bit;
    logic [MSG_W-1:0]    out_shift;

    assign cfg_len   = cfg_sr_q[CFG_W-1 -: LEN_W];
    assign cfg_min   = cfg_sr_q[2*CNT_W-1 -: CNT_W];
    assign cfg_max   = cfg_sr_q[CNT_W-1:0];
    assign eff_len   = (cfg_len > MSG_W_L) ? MSG_W_L : cfg_len;
    assign decode_en = cfg_done_q && (eff_len != '0);

    // One extra bit so a saturated hi plus any lo cannot wrap into the window.
    assign period    = {1'b0, hi_q} + {1'b0, lo_q};
    assign in_window = (period >= {1'b0, cfg_min}) && (period <= {1'b0, cfg_max});
    assign sym_bit   = (hi_q >= lo_q);
    assign last_bit  = ((bit_cnt_q + 1'b1) == eff_len);

    // Bits were shifted in at the LSB, so the oldest bit sits at eff_len-1.
    assign out_shift = msg_sr_q >> (eff_len - 1'b1 - out_cnt_q);

    always_comb begin
        state_d    = state_q;
        prev_str_d = str;
        mode_d     = mode;
        cfg_sr_d   = cfg_sr_q;
        cfg_cnt_d  = cfg_cnt_q;
        cfg_done_d = cfg_done_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        bit_cnt_d  = bit_cnt_q;
        out_cnt_d  = out_cnt_q;
        msg_sr_d   = msg_sr_q;
        msg_d      = 1'b0;
        frame_d    = 1'b0;
        err_d      = 1'b0;
`ifdef SAM_PARITY_EN
        par_phase_d = par_phase_q;
        par_acc_d   = par_acc_q;
`endif

        // Configuration shifter: a rising mode restarts at bit 0, bits past
        // the end of the word are ignored.
        if (mode && !mode_q) begin
            cfg_sr_d   = {cfg_sr_q[CFG_W-2:0], str};
            cfg_cnt_d  = CFG_ONE;
            cfg_done_d = 1'b0;
        end else if (mode && (cfg_cnt_q != CFG_FULL)) begin
            cfg_sr_d  = {cfg_sr_q[CFG_W-2:0], str};
            cfg_cnt_d = cfg_cnt_q + 1'b1;
            if (cfg_cnt_q == CFG_LAST) begin
                cfg_done_d = 1'b1;
            end
        end

        if (mode) begin
            // Abort: drop any partial message and counters.
            state_d   = S_IDLE;
            hi_d      = '0;
            lo_d      = '0;
            bit_cnt_d = '0;
            out_cnt_d = '0;
            msg_sr_d  = '0;
`ifdef SAM_PARITY_EN
            par_phase_d = 1'b0;
            par_acc_d   = 1'b0;
`endif
        end else if (!decode_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (str && !prev_str_q) begin
                        state_d = S_HIGH;
                        hi_d    = CNT_ONE;
                        lo_d    = '0;
                    end
                end

                S_HIGH: begin
                    if (str) begin
                        hi_d = (hi_q == CNT_MAX) ? hi_q : hi_q + 1'b1;
                    end else begin
                        state_d = S_LOW;
                        lo_d    = CNT_ONE;
                    end
                end

                S_LOW: begin
                    if (!str) begin
                        lo_d = (lo_q == CNT_MAX) ? lo_q : lo_q + 1'b1;
                    end else begin
                        // Symbol end; this rising edge also opens the next symbol
                        // unless the message is complete.
                        state_d = S_HIGH;
                        hi_d    = CNT_ONE;
                        lo_d    = '0;
`ifdef SAM_PARITY_EN
                        if (par_phase_q) begin
                            par_phase_d = 1'b0;
                            par_acc_d   = 1'b0;
                            bit_cnt_d   = '0;
                            if (in_window && (sym_bit == par_acc_q)) begin
                                state_d   = S_OUT;
                                out_cnt_d = '0;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else if (!in_window) begin
                            err_d = 1'b1;
                        end else begin
                            msg_sr_d  = {msg_sr_q[MSG_W-2:0], sym_bit};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            par_acc_d = par_acc_q ^ sym_bit;
                            if (last_bit) begin
                                par_phase_d = 1'b1;
                            end
                        end
`else
                        if (!in_window) begin
                            err_d = 1'b1;
                        end else begin
                            msg_sr_d  = {msg_sr_q[MSG_W-2:0], sym_bit};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (last_bit) begin
                                state_d   = S_OUT;
                                out_cnt_d = '0;
                                bit_cnt_d = '0;
                            end
                        end
`endif
                    end
                end

                S_OUT: begin
                    // str is ignored here; IDLE then needs a fresh rising edge.
                    if (out_cnt_q == eff_len) begin
                        state_d   = S_IDLE;
                        out_cnt_d = '0;
                    end else begin
                        frame_d   = 1'b1;
                        msg_d     = out_shift[0];
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            prev_str_q <= 1'b0;
            mode_q     <= 1'b0;
            cfg_sr_q   <= '0;
            cfg_cnt_q  <= '0;
            cfg_done_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            bit_cnt_q  <= '0;
            out_cnt_q  <= '0;
            msg_sr_q   <= '0;
            msg_q      <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef SAM_PARITY_EN
            par_phase_q <= 1'b0;
            par_acc_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prev_str_q <= prev_str_d;
            mode_q     <= mode_d;
            cfg_sr_q   <= cfg_sr_d;
            cfg_cnt_q  <= cfg_cnt_d;
            cfg_done_q <= cfg_done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            bit_cnt_q  <= bit_cnt_d;
            out_cnt_q  <= out_cnt_d;
            msg_sr_q   <= msg_sr_d;
            msg_q      <= msg_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
`ifdef SAM_PARITY_EN
            par_phase_q <= par_phase_d;
            par_acc_q   <= par_acc_d;
`endif
        end
    end

    assign msg         = msg_q;
    assign frame       = frame_q;
    assign cfg_done    = cfg_done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sam_pwm_rx.sv
// Bench for sam_pwm_rx with MSG_W=16, LEN_W=5, CNT_W=8. Stimulus is a list of
// (high, low) symbol lengths; a symbol-level model decides which symbols are
// accepted and what the message is, and a negedge monitor checks frame/msg/err.

module tb_sam_pwm_rx;

    localparam int MSG_W = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 8;
    localparam int CFG_W = LEN_W + 2 * CNT_W;
    localparam int SAT   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       str;
    logic       mode;
    logic       msg;
    logic       frame;
    logic       cfg_done;
    logic       err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    sam_pwm_rx #(
        .MSG_W(MSG_W),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .str        (str),
        .mode       (mode),
        .msg        (msg),
        .frame      (frame),
        .cfg_done   (cfg_done),
        .err        (err),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [0:0] exp_q[$];
    int         len_q[$];
    int         err_exp_q[$];
    int         run_len = 0;
    bit         mon_en  = 1'b0;

    // ---------------- reference model ----------------
    int m_len, m_min, m_max;
    int m_bits[$];
    int m_state;        // 0 collecting, 1 message ready, 2 message dropped
    bit m_par_phase;

    function automatic int eff_len();
        return (m_len > MSG_W) ? MSG_W : m_len;
    endfunction

    // -1 when rejected, else the decoded bit.
    function automatic int classify(int h, int l);
        int hs, ls, p;
        hs = (h > SAT) ? SAT : h;
        ls = (l > SAT) ? SAT : l;
        p  = hs + ls;
        if (p < m_min || p > m_max) return -1;
        return (hs >= ls) ? 1 : 0;
    endfunction

    function automatic int bits_xor();
        int x = 0;
        foreach (m_bits[i]) x = x ^ m_bits[i];
        return x;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            str = v;
            tick();
        end
    endtask

    task automatic cfg_load(input int len, input int mn, input int mx);
        logic [CFG_W-1:0] w;
        w = {LEN_W'(len), CNT_W'(mn), CNT_W'(mx)};
        mode = 1'b1;
        for (int i = CFG_W - 1; i >= 0; i--) begin
            if (i == 0) check("cfg_done_before_last_bit", cfg_done, 0);
            str = w[i];
            tick();
        end
        check("cfg_done_after_last_bit", cfg_done, 1);
        mode = 1'b0;
        str  = 1'b0;
        tick();
        m_len = len;
        m_min = mn;
        m_max = mx;
        m_bits.delete();
        m_state = 0;
        m_par_phase = 1'b0;
    endtask

    task automatic sym(input int h, input int l);
        int c;
        drive(1'b1, h);
        drive(1'b0, l);
        if (eff_len() == 0 || m_state != 0) return;
        c = classify(h, l);
        if (m_par_phase) begin
            m_par_phase = 1'b0;
            if (c >= 0 && c == bits_xor()) begin
                m_state = 1;
            end else begin
                err_exp_q.push_back(1);
                m_state = 2;
            end
            return;
        end
        if (c < 0) begin
            err_exp_q.push_back(1);
        end else begin
            m_bits.push_back(c);
            if (m_bits.size() == eff_len()) begin
`ifdef SAM_PARITY_EN
                m_par_phase = 1'b1;
`else
                m_state = 1;
`endif
            end
        end
    endtask

    task automatic push_expect();
        if (m_state == 1) begin
            foreach (m_bits[i]) exp_q.push_back(1'(m_bits[i]));
            len_q.push_back(eff_len());
        end
    endtask

    // Terminating rising edge, then idle long enough for the replay.
    task automatic finish_msg();
        push_expect();
        drive(1'b1, 1);
        drive(1'b0, eff_len() + 6);
        check("expected_bits_drained", exp_q.size(), 0);
        check("expected_errs_drained", err_exp_q.size(), 0);
        m_bits.delete();
        m_state = 0;
        m_par_phase = 1'b0;
    endtask

    task automatic rand_msg();
        int n = 0;
        int r, p, lo_p, h, l;
        while (m_state == 0 && n < 400) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                lo_p = (m_min < 2) ? 2 : m_min;
                if (r == 0)      p = lo_p;
                else if (r == 1) p = m_max;
                else             p = $urandom_range(lo_p, m_max);
                if (r == 2 && (p % 2) == 0) h = p / 2;
                else                        h = $urandom_range(1, p - 1);
                l = p - h;
            end else begin
                h = $urandom_range(1, 50);
                l = $urandom_range(1, 50);
            end
            sym(h, l);
            n++;
        end
        finish_msg();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (err) begin
                total++;
                if (err_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL err_pulse: got err=1 expected no error at %0t", $time);
                end else begin
                    void'(err_exp_q.pop_front());
                end
            end
            if (frame) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_bit: got frame=1 msg=%0b expected frame=0 at %0t", msg, $time);
                end else begin
                    logic [0:0] eb;
                    eb = exp_q.pop_front();
                    if (msg !== eb) begin
                        bad++;
                        $display("FAIL msg_bit: got %0b expected %0b at %0t", msg, eb, $time);
                    end
                end
                run_len++;
            end else begin
                total++;
                if (msg !== 1'b0) begin
                    bad++;
                    $display("FAIL msg_idle: got %0b expected 0 at %0t", msg, $time);
                end
                if (run_len > 0) begin
                    total++;
                    if (len_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_len: got run %0d expected no frame", run_len);
                    end else begin
                        int el;
                        el = len_q.pop_front();
                        if (run_len != el) begin
                            bad++;
                            $display("FAIL frame_len: got %0d expected %0d", run_len, el);
                        end
                    end
                    run_len = 0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        reset = 1'b0;
        str   = 1'b0;
        mode  = 1'b0;
        m_len = 0; m_min = 0; m_max = 0; m_state = 0; m_par_phase = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_msg", msg, 0);
        check("reset_frame", frame, 0);
        check("reset_cfg_done", cfg_done, 0);
        check("reset_err", err, 0);
        check("reset_state", dbg_state, 0);
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        // Config load and basic decode: 1,0,1,1.
        cfg_load(4, 10, 60);
        sym(8, 4); sym(3, 9); sym(8, 4); sym(8, 4);
        finish_msg();

        // Period window: P=6 and P=70 rejected mid-message.
        sym(8, 4); sym(3, 3); sym(3, 9); sym(40, 30); sym(8, 4); sym(8, 4);
        finish_msg();

        // hi == lo decodes as 1; window edges P=10 and P=60.
        sym(6, 6); sym(2, 8); sym(30, 30); sym(2, 10);
        finish_msg();

        // Saturation: 300-cycle high run, hi sticks at 255, P > 255.
        cfg_load(2, 10, 255);
        sym(300, 5); sym(8, 4); sym(3, 9);
        finish_msg();

        // Abort after 2 of 4 bits, then a fresh 3-bit message.
        cfg_load(4, 10, 60);
        sym(8, 4); sym(8, 4);
        cfg_load(3, 10, 60);
        sym(3, 9); sym(8, 4); sym(3, 9);
        finish_msg();

        // LEN=0 keeps decode disabled: no frame, no err.
        cfg_load(0, 10, 60);
        sym(8, 4); sym(3, 3); sym(3, 9);
        finish_msg();

        // LEN above MSG_W is clamped to MSG_W.
        cfg_load(25, 10, 60);
        rand_msg();

`ifdef SAM_PARITY_EN
        cfg_load(4, 10, 60);
        sym(8, 4); sym(3, 9); sym(8, 4); sym(8, 4); sym(8, 4);
        finish_msg();
        sym(8, 4); sym(3, 9); sym(8, 4); sym(8, 4); sym(3, 9);
        finish_msg();
`endif

        // Randomized configurations and messages.
        for (int t = 0; t < 6; t++) begin
            int mn, mx;
            mn = $urandom_range(2, 20);
            mx = mn + $urandom_range(5, 60);
            cfg_load($urandom_range(1, 20), mn, mx);
            rand_msg();
            if ($urandom_range(0, 1) == 1) rand_msg();
        end

        // Asynchronous reset while the message is being replayed.
        cfg_load(4, 10, 60);
        sym(8, 4); sym(3, 9); sym(3, 9); sym(8, 4);
`ifdef SAM_PARITY_EN
        sym(3, 9);
`endif
        push_expect();
        drive(1'b1, 1);
        drive(1'b0, 1);
        k = 0;
        while (!frame && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("frame_rose_before_reset", frame, 1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("reset_mid_out_frame", frame, 0);
        check("reset_mid_out_cfg_done", cfg_done, 0);
        check("reset_mid_out_msg", msg, 0);
        exp_q.delete();
        len_q.delete();
        err_exp_q.delete();
        run_len = 0;
        m_bits.delete();
        m_state = 0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Decode still works after the reset.
        cfg_load(3, 10, 60);
        sym(8, 4); sym(3, 9); sym(8, 4);
`ifdef SAM_PARITY_EN
        sym(3, 9);
`endif
        finish_msg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
